moving_avg_filter: RTL and testbench

//   Multi-channel moving-average FIR: each output is the mean of the last 2**LOG2_N samples.

---
 rtl/moving_avg_filter.sv | 98 +++++++++
 tb/tb_moving_avg_filter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/moving_avg_filter.sv
// moving_avg_filter: multi-channel moving-average FIR over the last 2**LOG2_N samples.
// Each channel keeps a circular history buffer and a running sum, so every accepted
// sample costs one add and one subtract instead of an N-input adder tree. A bypass
// mode passes raw samples while still tracking history, and a synchronous clear
// flushes all history.
module moving_avg_filter #(
    parameter int DATA_W   = 24,
    parameter int LOG2_N   = 3,
    parameter int CHANNELS = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         bypass,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         primed
);

    localparam int N      = 1 << LOG2_N;
    localparam int ACC_W  = DATA_W + LOG2_N;
    // A window of one still needs a one-bit pointer; it simply never leaves 0.
    localparam int PTR_W  = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int FILL_W = $clog2(N + 1);

    // History, running sums and shared window bookkeeping.
    logic signed [DATA_W-1:0] hist_mem [CHANNELS][N];
    logic signed [ACC_W-1:0]  acc      [CHANNELS];
    logic [PTR_W-1:0]         wptr;
    logic [FILL_W-1:0]        fill;

    // Per-channel combinational view of the current edge.
    logic signed [DATA_W-1:0] sample   [CHANNELS];
    logic signed [DATA_W-1:0] oldest   [CHANNELS];
    logic signed [ACC_W-1:0]  sum      [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] next_out;

    logic accept;
    assign accept = in_valid && !clear;

    // Unpack samples, form the new running sum and the candidate output word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sample[c] = in_data[c*DATA_W +: DATA_W];
            oldest[c] = hist_mem[c][wptr];
            // Sign-extending casts keep the sum exact; ACC_W bits cannot overflow.
            sum[c]    = acc[c] + ACC_W'(sample[c]) - ACC_W'(oldest[c]);
            // Arithmetic shift floors toward -inf; the quotient always fits DATA_W.
            next_out[c*DATA_W +: DATA_W] = bypass ? sample[c] : DATA_W'(sum[c] >>> LOG2_N);
        end
    end

    // Window state, accumulators and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the history buffer is reset like any other register because a stale
            // sample would otherwise leak into the warm-up average after reset.
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < N; i++) hist_mem[c][i] <= '0;
                acc[c] <= '0;
            end
            wptr      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < N; i++) hist_mem[c][i] <= '0;
                acc[c] <= '0;
            end
            wptr      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int c = 0; c < CHANNELS; c++) begin
                hist_mem[c][wptr] <= sample[c];
                acc[c]            <= sum[c];
            end
            wptr <= (wptr == PTR_W'(N - 1)) ? '0 : wptr + 1'b1;
            if (fill != FILL_W'(N)) fill <= fill + 1'b1;
            // Primed once this accept brings the fill count to N.
            primed    <= primed || (fill >= FILL_W'(N - 1));
            out_valid <= 1'b1;
            out_data  <= next_out;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_avg_filter.sv
// tb_moving_avg_filter: directed scenarios plus randomized traffic, all checked every
// cycle against a queue-based model of the last N samples per channel.
module tb_moving_avg_filter;

    localparam int DATA_W   = 24;
    localparam int LOG2_N   = 3;
    localparam int CHANNELS = 2;
    localparam int N        = 1 << LOG2_N;

    logic                       clock;
    logic                       reset_n;
    logic                       clear;
    logic                       bypass;
    logic                       in_valid;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic                       out_valid;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       primed;

    moving_avg_filter #(
        .DATA_W  (DATA_W),
        .LOG2_N  (LOG2_N),
        .CHANNELS(CHANNELS)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (clear),
        .bypass   (bypass),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .primed   (primed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    bit run_checks = 1'b0;

    // Model: samples since reset/clear, keeping only the newest N per channel.
    longint                     win [CHANNELS][$];
    int                         model_fill;
    logic                       exp_valid;
    logic [CHANNELS*DATA_W-1:0] exp_data;
    logic                       exp_primed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ch(input string name, input int c, input int expected);
        logic [DATA_W-1:0] exp_w;
        exp_w = DATA_W'(expected);
        check(name, 64'(out_data[c*DATA_W +: DATA_W]), 64'(exp_w));
    endtask

    function automatic longint floor_div_n(input longint s);
        longint q;
        q = s / N;
        if ((s % N != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_flush();
        for (int c = 0; c < CHANNELS; c++) win[c].delete();
        model_fill = 0;
        exp_valid  = 1'b0;
        exp_data   = '0;
        exp_primed = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic clr, input logic byp,
                              input logic [CHANNELS*DATA_W-1:0] d);
        longint s;
        logic signed [DATA_W-1:0] x;
        logic [DATA_W-1:0] o;
        if (clr) begin
            model_flush();
        end else if (v) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x = d[c*DATA_W +: DATA_W];
                win[c].push_back(longint'(x));
                if (win[c].size() > N) void'(win[c].pop_front());
                s = 0;
                foreach (win[c][i]) s += win[c][i];
                o = byp ? x : DATA_W'(floor_div_n(s));
                exp_data[c*DATA_W +: DATA_W] = o;
            end
            exp_valid  = 1'b1;
            model_fill = (model_fill < N) ? model_fill + 1 : N;
            exp_primed = (model_fill == N);
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clock) begin
        if (run_checks) begin
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("out_data", 64'(out_data), 64'(exp_data));
            check("primed", 64'(primed), 64'(exp_primed));
        end
    end

    // One clock: drive after the falling edge, update the model at the rising edge.
    task automatic step(input logic v, input logic clr, input logic byp, input int d0, input int d1);
        logic [CHANNELS*DATA_W-1:0] d;
        d = {DATA_W'(d1), DATA_W'(d0)};
        in_valid = v;
        clear    = clr;
        bypass   = byp;
        in_data  = d;
        @(posedge clock);
        model_edge(v, clr, byp, d);
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        bypass   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_flush();
        #3;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_primed", 64'(primed), 64'd0);
        @(negedge clock);
        reset_n    = 1'b1;
        run_checks = 1'b1;
        idle();

        // Ramp-in: warm-up averages grow by 100 per sample.
        for (int k = 1; k <= N; k++) begin
            step(1'b1, 1'b0, 1'b0, 800, -800);
            check_ch("ramp_ch0", 0, 100 * k);
            check_ch("ramp_ch1", 1, -100 * k);
            check("ramp_primed", 64'(primed), 64'(k == N));
        end

        // Steady decay as zeros displace the 800s.
        for (int k = 1; k <= N; k++) begin
            step(1'b1, 1'b0, 1'b0, 0, 0);
            check_ch("decay_ch0", 0, 800 - 100 * k);
        end

        // Floor rounding of a lone negative sample.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, -1, 7);
        check_ch("floor_ch0", 0, -1);
        check_ch("floor_ch1", 1, 0);

        // Gapped valid: pulses one cycle after each accept, data held in between.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 80, 0);
            check("gap_pulse", 64'(out_valid), 64'd1);
            check_ch("gap_ch0", 0, 10 * k);
            idle();
            idle();
            check("gap_quiet", 64'(out_valid), 64'd0);
            check_ch("gap_hold", 0, 10 * k);
        end

        // Clear beats in_valid and discards the sample.
        step(1'b1, 1'b1, 1'b0, 800, 800);
        check_ch("clr_ch0", 0, 0);
        check("clr_valid", 64'(out_valid), 64'd0);
        check("clr_primed", 64'(primed), 64'd0);
        step(1'b1, 1'b0, 1'b0, 80, 0);
        check_ch("post_clr_ch0", 0, 10);

        // Bypass still fills history, so the first averaged output is already 800.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < N; k++) begin
            step(1'b1, 1'b0, 1'b1, 800, -5);
            check_ch("byp_ch0", 0, 800);
        end
        step(1'b1, 1'b0, 1'b0, 800, 0);
        check_ch("unbyp_ch0", 0, 800);

        // Extremes: full-scale positive then negative windows with no wrap.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < N; k++) step(1'b1, 1'b0, 1'b0, 32'h7FFFFF, -8388608);
        check_ch("max_ch0", 0, 32'h7FFFFF);
        check_ch("min_ch1", 1, -8388608);
        for (int k = 0; k < N; k++) step(1'b1, 1'b0, 1'b0, -8388608, 32'h7FFFFF);
        check_ch("min_ch0", 0, -8388608);
        check_ch("max_ch1", 1, 32'h7FFFFF);

        // Asynchronous reset between edges.
        #2;
        reset_n = 1'b0;
        model_flush();
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_data", 64'(out_data), 64'd0);
        check("async_primed", 64'(primed), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic across valid, clear, bypass and full-range data.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(99) < 60), ($urandom_range(99) < 3), ($urandom_range(99) < 25),
                 int'($urandom), int'($urandom));
        end

        run_checks = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
